// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer for the 3x3 line buffer.
// Clears the line buffer, streams one IMG_WIDTH*IMG_HEIGHT frame out of
// pixel memory into it, and pauses read issue while downstream stalls.
// It then counts the returned windows and pulses done.
// Optional build macro CONV_FRAME_CTRL_PERF_EN adds the stall and frame-length
// performance counters (perf_stall_cycles, perf_frame_cycles).
//
// Handshake: a read is issued by holding mem_rd_en high for one cycle with
// mem_addr valid. mem_rd_data is valid the following cycle, and the pixel
// goes to the line buffer one cycle after that with lb_pixel_valid high.
// There is no back-pressure on an issued read; stall only blocks new issues.
module conv_frame_ctrl #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              stall,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              lb_clear,
    output logic [7:0]        lb_pixel,
    output logic              lb_pixel_valid,
    input  logic              lb_window_valid,
    output logic              busy,
    output logic              done,
    output logic [15:0]       win_count,
    output logic [7:0]        frame_count,
    output logic              err_overrun
`ifdef CONV_FRAME_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_frame_cycles
`endif
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int NWIN  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);
    localparam int PIX_W = $clog2(NPIX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PIX_W-1:0]  pix_idx;
    logic [ADDR_W-1:0] base_q;
    logic              rd_pipe;      // read issued last cycle; its data is on mem_rd_data now

    logic              accept;       // start honoured this cycle
    logic              abort_hit;    // abort honoured this cycle
    logic              issue;        // issue a memory read at this edge
    logic              drain_exit;   // frame complete at this edge
    logic              in_flight;
    logic              win_at_max;
    logic              overrun;

    assign in_flight  = mem_rd_en | rd_pipe;
    assign win_at_max = (win_count == 16'(NWIN));
    assign overrun    = lb_window_valid & (~busy | win_at_max);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle control decisions
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        abort_hit  = 1'b0;
        issue      = 1'b0;
        drain_exit = 1'b0;
        case (state)
            S_IDLE: begin
                // abort outranks start, so a simultaneous pair leaves us idle
                if (start && !abort) begin
                    accept     = 1'b1;
                    state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_IDLE;
                end else if (!stall) begin
                    issue = 1'b1;
                    if (pix_idx == PIX_W'(NPIX - 1)) begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // a window arriving now is counted first; exit is re-evaluated next cycle
                if (abort) begin
                    abort_hit  = 1'b1;
                    state_next = S_IDLE;
                end else if (win_at_max && !in_flight && !lb_window_valid) begin
                    drain_exit = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Registered datapath: read issue, read pipeline, counters and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            lb_clear       <= 1'b0;
            lb_pixel       <= '0;
            lb_pixel_valid <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            win_count      <= '0;
            frame_count    <= '0;
            err_overrun    <= 1'b0;
            pix_idx        <= '0;
            base_q         <= '0;
            rd_pipe        <= 1'b0;
        end else begin
            lb_clear  <= accept | abort_hit;
            mem_rd_en <= issue;
            if (issue) begin
                // address wraps modulo 2^ADDR_W on purpose
                mem_addr <= base_q + ADDR_W'(pix_idx);
                pix_idx  <= pix_idx + PIX_W'(1);
            end
            // an abort drops whatever is still travelling through the read pipe
            rd_pipe        <= mem_rd_en & ~abort_hit;
            lb_pixel_valid <= rd_pipe & ~abort_hit;
            if (rd_pipe && !abort_hit) begin
                lb_pixel <= mem_rd_data;
            end
            done <= drain_exit;
            if (accept) begin
                busy <= 1'b1;
            end else if (drain_exit || abort_hit) begin
                busy <= 1'b0;
            end
            if (drain_exit) begin
                frame_count <= frame_count + 8'd1;
            end
            if (accept) begin
                base_q    <= base_addr;
                pix_idx   <= '0;
                win_count <= '0;
            end else if (lb_window_valid && busy && !win_at_max) begin
                win_count <= win_count + 16'd1;
            end
            if (overrun) begin
                err_overrun <= 1'b1;
            end else if (accept) begin
                err_overrun <= 1'b0;
            end
        end
    end

`ifdef CONV_FRAME_CTRL_PERF_EN
    // Saturating performance counters, cleared when a frame is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_frame_cycles <= '0;
        end else if (accept) begin
            perf_stall_cycles <= '0;
            perf_frame_cycles <= '0;
        end else begin
            if (state == S_RUN && stall && perf_stall_cycles != 32'hFFFF_FFFF) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            // CLEAR, RUN, DRAIN and the idle cycle carrying the done pulse
            if ((state != S_IDLE || done) && perf_frame_cycles != 32'hFFFF_FFFF) begin
                perf_frame_cycles <= perf_frame_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl with an 8x8 frame, a pixel memory model and a
// behavioural 3x3 line buffer model that emits one window per pixel whose
// row and column are both at least 2.
module tb_conv_frame_ctrl;

    localparam int W      = 8;
    localparam int H      = 8;
    localparam int NPIX   = W * H;
    localparam int NWIN   = (W - 2) * (H - 2);
    localparam int ADDR_W = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              stall = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data = '0;
    logic              lb_clear;
    logic [7:0]        lb_pixel;
    logic              lb_pixel_valid;
    logic              lb_window_valid;
    logic              busy;
    logic              done;
    logic [15:0]       win_count;
    logic [7:0]        frame_count;
    logic              err_overrun;
`ifdef CONV_FRAME_CTRL_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_frame_cycles;
`endif

    conv_frame_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .base_addr      (base_addr),
        .stall          (stall),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .lb_clear       (lb_clear),
        .lb_pixel       (lb_pixel),
        .lb_pixel_valid (lb_pixel_valid),
        .lb_window_valid(lb_window_valid),
        .busy           (busy),
        .done           (done),
        .win_count      (win_count),
        .frame_count    (frame_count),
        .err_overrun    (err_overrun)
`ifdef CONV_FRAME_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_frame_cycles(perf_frame_cycles)
`endif
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- environment models ----------------
    logic [7:0] seed = 8'h00;

    function automatic logic [7:0] pix_of(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ seed;
    endfunction

    // pixel memory: one-cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= pix_of(mem_addr);
    end

    // line buffer: windows exist for pixels with row>=2 and col>=2
    int   lb_cnt;
    logic lb_win;
    logic inj = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lb_cnt <= 0;
            lb_win <= 1'b0;
        end else if (lb_clear) begin
            lb_cnt <= 0;
            lb_win <= 1'b0;
        end else begin
            lb_win <= lb_pixel_valid && ((lb_cnt % W) >= 2) && ((lb_cnt / W) >= 2);
            if (lb_pixel_valid) lb_cnt <= lb_cnt + 1;
        end
    end
    assign lb_window_valid = lb_win | inj;

    // stall generator: 0 none, 1 random, 2 one burst after read 10
    int stall_mode = 0;
    int burst_left = 0;
    int n_rd = 0;
    always @(posedge clk) begin
        #1;
        case (stall_mode)
            1:       stall = ($urandom_range(0, 3) == 0);
            2: begin
                if (n_rd >= 10 && burst_left > 0) begin
                    stall = 1'b1;
                    burst_left--;
                end else begin
                    stall = 1'b0;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    logic [ADDR_W-1:0] addr_q[$];
    logic [7:0]        exp_q[$];
    logic [7:0]        exp_pix;
    int n_clear, n_done, done_cyc, clear_cyc, first_rd_cyc, last_rd_cyc, pv_after;
    bit watch_abort;

    always @(negedge clk) begin
        if (rst_n) begin
            if (lb_clear) begin
                n_clear++;
                clear_cyc = cyc;
            end
            if (lb_pixel_valid) begin
                if (watch_abort) begin
                    pv_after++;
                end else begin
                    check_eq("pix_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        exp_pix = exp_q.pop_front();
                        check_eq("pixel", lb_pixel, exp_pix);
                    end
                end
            end
            if (mem_rd_en) begin
                if (n_rd == 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                n_rd++;
                addr_q.push_back(mem_addr);
                exp_q.push_back(pix_of(mem_addr));
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int exp_fc = 0;

    task automatic clear_mon();
        addr_q.delete();
        exp_q.delete();
        n_rd = 0; n_clear = 0; n_done = 0; pv_after = 0;
        done_cyc = -1; clear_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
        watch_abort = 0;
        seed = 8'($urandom);
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] b);
        clear_mon();
        @(posedge clk); #1;
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        base_addr = 16'($urandom);
        check_eq("busy_rise", busy, 1);
        check_eq("err_cleared_on_start", err_overrun, 0);
    endtask

    task automatic wait_reads(input int n);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (n_rd >= n) break;
        end
        check_eq("wait_reads", n_rd >= n, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (n_done > 0) break;
        end
        check_eq("done_seen", n_done > 0, 1);
        repeat (10) @(posedge clk);
        #1;
        exp_fc = (exp_fc + 1) % 256;
    endtask

    task automatic end_checks(input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] ea;
        check_eq("n_reads", n_rd, NPIX);
        for (int i = 0; i < addr_q.size(); i++) begin
            ea = b + 16'(i);
            check_eq("addr", addr_q[i], ea);
        end
        check_eq("n_clear", n_clear, 1);
        check_eq("clear_before_read", clear_cyc < first_rd_cyc, 1);
        check_eq("win_count", win_count, NWIN);
        check_eq("n_done", n_done, 1);
        check_eq("frame_count", frame_count, exp_fc);
        check_eq("busy_end", busy, 0);
        check_eq("err_end", err_overrun, 0);
        check_eq("sb_empty", exp_q.size(), 0);
`ifdef CONV_FRAME_CTRL_PERF_EN
        check_eq("perf_frame", perf_frame_cycles, done_cyc - clear_cyc + 1);
`endif
    endtask

    // ---------------- test sequence ----------------
    int base_lat;
    logic [ADDR_W-1:0] rb;

    initial begin
        #23;
        check_eq("rst_mem_rd_en", mem_rd_en, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_lb_clear", lb_clear, 0);
        check_eq("rst_lb_pixel", lb_pixel, 0);
        check_eq("rst_lb_pixel_valid", lb_pixel_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_win_count", win_count, 0);
        check_eq("rst_frame_count", frame_count, 0);
        check_eq("rst_err", err_overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // unstalled frame at 0x0100
        stall_mode = 0;
        start_frame(16'h0100);
        wait_done();
        end_checks(16'h0100);
        check_eq("read_span_nostall", last_rd_cyc - first_rd_cyc, NPIX - 1);
        base_lat = done_cyc - clear_cyc;
`ifdef CONV_FRAME_CTRL_PERF_EN
        check_eq("perf_stall_zero", perf_stall_cycles, 0);
`endif

        // same frame with a 5-cycle stall burst after read 10
        stall_mode = 2;
        burst_left = 5;
        start_frame(16'h0100);
        wait_done();
        end_checks(16'h0100);
        check_eq("read_span_stall", last_rd_cyc - first_rd_cyc, NPIX - 1 + 5);
        check_eq("done_delay_stall", (done_cyc - clear_cyc) - base_lat, 5);
`ifdef CONV_FRAME_CTRL_PERF_EN
        check_eq("perf_stall_five", perf_stall_cycles, 5);
`endif
        stall_mode = 0;

        // abort during RUN after 20 reads
        start_frame(16'h0200);
        wait_reads(20);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_eq("abort_lb_clear", lb_clear, 1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_read", mem_rd_en, 0);
        exp_q.delete();
        watch_abort = 1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_no_pixels", pv_after, 0);
        check_eq("abort_no_done", n_done, 0);
        check_eq("abort_frame_count", frame_count, exp_fc);
        check_eq("abort_idle_busy", busy, 0);
        start_frame(16'h0300);
        wait_done();
        end_checks(16'h0300);

        // window strobe while idle raises sticky error
        @(posedge clk); #1;
        inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        check_eq("inject_err", err_overrun, 1);
        repeat (5) @(posedge clk);
        #1;
        check_eq("inject_err_sticky", err_overrun, 1);
        start_frame(16'h0040);
        wait_done();
        end_checks(16'h0040);

        // start together with abort in IDLE
        clear_mon();
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_eq("start_abort_busy", busy, 0);
        check_eq("start_abort_clear", lb_clear, 0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("start_abort_still_idle", busy, 0);
        check_eq("start_abort_no_read", n_rd, 0);

        // address wrap through 0xFFFF
        start_frame(16'hFFF0);
        wait_done();
        end_checks(16'hFFF0);

        // start pulsed again mid-frame is ignored
        start_frame(16'h0500);
        wait_reads(30);
        base_addr = 16'h7777;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("restart_busy", busy, 1);
        wait_done();
        end_checks(16'h0500);

        // randomized frames with random stalls and bases
        stall_mode = 1;
        for (int f = 0; f < 3; f++) begin
            rb = 16'($urandom);
            start_frame(rb);
            wait_done();
            end_checks(rb);
        end
        stall_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global time guard
    initial begin
        #2000000;
        check_eq("global_timeout", 1'b0, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer for the 3x3 line buffer in the conv pipeline.
- On a start pulse it clears the line buffer, streams one W*H frame from pixel memory into it, and pauses issue while downstream stalls.
- Counts the windows the line buffer returns, then signals done.
- Sits between the image RAM and the line buffer / conv engine.

Parameters:
- IMG_WIDTH, 64, pixels per row (>=3); must match the line buffer.
- IMG_HEIGHT, 64, rows per frame (>=3).
- ADDR_W, 16, memory address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle frame request; honoured only in IDLE.
- abort  in  1  cancel current frame; priority over start.
- base_addr  in  ADDR_W  frame start address, latched on accepted start.
- stall  in  1  downstream not ready; blocks new memory reads.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  read address.
- mem_rd_data  in  8  read data, valid the cycle after mem_rd_en.
- lb_clear  out  1  active-high synchronous clear to the line buffer.
- lb_pixel  out  8  pixel to the line buffer.
- lb_pixel_valid  out  1  pixel strobe to the line buffer.
- lb_window_valid  in  1  window strobe from the line buffer.
- busy  out  1  frame in progress.
- done  out  1  one-cycle frame-complete pulse.
- win_count  out  16  windows received this frame.
- frame_count  out  8  frames completed, wraps at 255->0.
- err_overrun  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE.
  - All outputs 0, including mem_addr, lb_pixel, counters and err_overrun.
  - Internal pixel index and read-pipeline valid cleared.
- All outputs are registered.
- Constants: NPIX = IMG_WIDTH*IMG_HEIGHT; NWIN = (IMG_WIDTH-2)*(IMG_HEIGHT-2).
- States: IDLE, CLEAR, RUN, DRAIN.
- IDLE:
  - start=1 and abort=0 -> CLEAR.
  - Latch base_addr; zero pix_idx and win_count; clear err_overrun.
  - busy rises the cycle after start.
- CLEAR:
  - lb_clear=1 for exactly this one cycle, then -> RUN.
- RUN:
  - Each cycle with stall=0: mem_rd_en=1, mem_addr=base+pix_idx, pix_idx++.
  - With stall=1: mem_rd_en=0 and pix_idx holds.
  - When read NPIX-1 issues -> DRAIN.
- Address arithmetic: base+pix_idx is modulo 2^ADDR_W; it wraps silently, with no error.
- Read pipeline:
  - mem_rd_en in cycle t gives data in t+1.
  - The block registers it: lb_pixel=mem_rd_data and lb_pixel_valid=1 in cycle t+2.
  - stall never cancels an issued read; in-flight data is always delivered.
  - lb_pixel_valid is 0 otherwise; lb_pixel holds its last value.
- Window counting: win_count increments on each lb_window_valid while busy.
- DRAIN:
  - No reads issued.
  - When win_count==NWIN and no read is in flight: done=1 for one cycle, frame_count++, busy=0, -> IDLE.
- abort in CLEAR/RUN/DRAIN:
  - Next state IDLE; lb_clear=1 for one cycle.
  - In-flight read data is discarded (lb_pixel_valid forced 0).
  - busy=0; done is not asserted; frame_count unchanged.
- start while busy: ignored, no error.
- err_overrun is set (sticky until the next accepted start) on either:
  - lb_window_valid while not busy;
  - lb_window_valid when win_count already equals NWIN.
- Simultaneous events:
  - start with abort in IDLE: abort wins, stay IDLE.
  - window strobe in the same cycle the DRAIN exit condition is met: counted first, then evaluated next cycle.

Optional Feature:
- Macro: CONV_FRAME_CTRL_PERF_EN.
- Enabled, adds two outputs (the ports do not exist when disabled):
  - perf_stall_cycles (32): counts RUN cycles with stall=1.
  - perf_frame_cycles (32): counts cycles from CLEAR through the done cycle.
- Both perf counters clear on an accepted start and saturate at 0xFFFFFFFF.
- Disabled: no such ports and no counter logic.

Test Plan:
- W=H=8, base=0x0100, stall=0, line buffer model attached:
  - mem_addr runs 0x0100..0x013F on 64 consecutive cycles;
  - lb_clear pulses once, before the first read;
  - win_count ends at 36; one done pulse; frame_count=1.
- Same frame with stall high for 5 cycles after read 10: exactly 64 reads, no address skipped or repeated, win_count=36, done 5 cycles later than the unstalled run.
- abort asserted during RUN after 20 reads:
  - next cycle IDLE with lb_clear=1;
  - no lb_pixel_valid after abort; no done; frame_count unchanged;
  - a following start completes normally with 36 windows.
- Injected lb_window_valid in IDLE -> err_overrun=1 and stays 1; next accepted start clears it.
- base=0xFFF0 with W=H=8: addresses wrap 0xFFF0..0xFFFF then 0x0000..0x002F; frame completes with no error.
- start pulsed again mid-frame: ignored, busy stays high, single done at frame end. Under CONV_FRAME_CTRL_PERF_EN, perf_stall_cycles=5 for the stall test.
